// File: rtl/reg_file_banked.sv
// reg_file_banked: SFR block (INDF/FSR, STATUS, OPTION, TMR0 with prescaler, ports) plus banked GPR RAM.
module reg_file_banked #(
    parameter int BANKS   = 4,
    parameter int N_PORTS = 3,
    parameter int PORT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4:0]                f_adrs,
    input  logic                      f_wr,
    input  logic [7:0]                f_in_data,
    output logic [7:0]                f_out_data,
    input  logic [7:0]                pcl_in,
    output logic                      PCL_wr,
    input  logic                      tmr0_inc,
    output logic                      tmr0_ovf,
    input  logic                      C_en,
    input  logic                      DC_en,
    input  logic                      Z_en,
    input  logic                      C_new,
    input  logic                      DC_new,
    input  logic                      Z_new,
    input  logic                      SLEEP,
    input  logic                      CLRWDT,
    input  logic                      wdtmr,
    output logic                      C,
    output logic [7:0]                FSR,
    input  logic [N_PORTS*PORT_W-1:0] port_in,
    output logic [N_PORTS*PORT_W-1:0] port_out,
    output logic [N_PORTS*PORT_W-1:0] port_oe
);
    localparam int RAM_N = BANKS * 20;

    logic [7:0] ram [RAM_N];
    logic [7:0] tmr0, pre, rdata;
    logic [1:0] rp, bank, pk, tk;
    logic       to_n, pd_n, z, dc, c, t0if, psa, tmr_wr_d;
    logic [2:0] ps;
    logic [4:0] eff;
    logic [6:0] ram_idx;
    logic [8:0] pre_nxt;
    logic [N_PORTS*PORT_W-1:0] sync1, sync2, tris;
    logic ind, ind_null, wr_en, is_gpr, is_port, is_tris;
    logic tmr_wr, st_wr, opt_wr, any_en, inc_ok, pre_hit, step, wrap;

    assign ind      = f_adrs == 5'd0;
    assign eff      = ind ? FSR[4:0] : f_adrs;
    assign ind_null = ind && FSR[4:0] == 5'd0;
    assign bank     = (ind ? FSR[6:5] : rp) & 2'(BANKS - 1);
    assign ram_idx  = 7'(bank) * 7'd20 + 7'(eff) - 7'd12;
    assign pk       = 2'(eff - 5'd5);
    assign tk       = 2'(eff - 5'd8);
    assign is_gpr   = eff >= 5'h0C;
    assign is_port  = eff >= 5'h05 && eff <= 5'h07 && int'(pk) < N_PORTS;
    assign is_tris  = eff >= 5'h08 && eff <= 5'h0A && int'(tk) < N_PORTS;
    assign wr_en    = f_wr && !ind_null;
    assign tmr_wr   = wr_en && eff == 5'h01;
    assign PCL_wr   = wr_en && eff == 5'h02;
    assign st_wr    = wr_en && eff == 5'h03;
    assign opt_wr   = wr_en && eff == 5'h0B;
    assign any_en   = C_en | DC_en | Z_en;
    assign C        = c;
    assign port_oe  = ~tris;

    // Increments are blocked in the TMR0 write cycle and the one after it.
    assign inc_ok  = tmr0_inc && !tmr_wr && !tmr_wr_d;
    assign pre_nxt = {1'b0, pre} + 9'd1;
    assign pre_hit = pre_nxt == (9'd2 << ps);
    assign step    = inc_ok && (psa || pre_hit);
    assign wrap    = step && tmr0 == 8'hFF;

    always_comb begin
        rdata = 8'h00;
        case (eff)
            5'h01: rdata = tmr0;
            5'h02: rdata = pcl_in;
            5'h03: rdata = {1'b0, rp, to_n, pd_n, z, dc, c};
            5'h04: rdata = FSR;
            5'h0B: rdata = {t0if, 3'b000, psa, ps};
            default: rdata = is_gpr  ? ram[ram_idx] :
                             is_port ? 8'(sync2[int'(pk)*PORT_W +: PORT_W]) :
                             is_tris ? 8'(tris[int'(tk)*PORT_W +: PORT_W]) : 8'h00;
        endcase
        f_out_data = ind_null ? 8'h00 : rdata;
    end

    always_ff @(posedge clk)
        if (wr_en && is_gpr) ram[ram_idx] <= f_in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            FSR  <= 8'h00;
            rp   <= 2'b00;
            to_n <= 1'b1;
            pd_n <= 1'b1;
            {z, dc, c} <= 3'b000;
        end else begin
            if (wr_en && eff == 5'h04) FSR <= f_in_data;
            if (st_wr) rp <= f_in_data[6:5];
            if (any_en) begin
                z  <= Z_en  ? Z_new  : z;
                dc <= DC_en ? DC_new : dc;
                c  <= C_en  ? C_new  : c;
            end else if (st_wr) begin
                {z, dc, c} <= f_in_data[2:0];
            end
            if (CLRWDT) begin
                to_n <= 1'b1;
                pd_n <= 1'b1;
            end else if (SLEEP) begin
                to_n <= 1'b1;
                pd_n <= 1'b0;
            end else if (wdtmr) begin
                to_n <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr0     <= 8'h00;
            pre      <= 8'h00;
            tmr_wr_d <= 1'b0;
            tmr0_ovf <= 1'b0;
            t0if     <= 1'b0;
            psa      <= 1'b1;
            ps       <= 3'b111;
        end else begin
            tmr_wr_d <= tmr_wr;
            tmr0_ovf <= wrap;
            if (tmr_wr) tmr0 <= f_in_data;
            else if (step) tmr0 <= tmr0 + 8'd1;
            if (tmr_wr || opt_wr || psa) pre <= 8'h00;
            else if (inc_ok) pre <= pre_hit ? 8'h00 : pre_nxt[7:0];
            t0if <= wrap || (opt_wr ? t0if && f_in_data[7] : t0if);
            if (opt_wr) begin
                psa <= f_in_data[3];
                ps  <= f_in_data[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            port_out <= '0;
            tris     <= '1;
        end else begin
            sync1 <= port_in;
            sync2 <= sync1;
            if (wr_en && is_port) port_out[int'(pk)*PORT_W +: PORT_W] <= f_in_data[PORT_W-1:0];
            if (wr_en && is_tris) tris[int'(tk)*PORT_W +: PORT_W] <= f_in_data[PORT_W-1:0];
        end
    end
endmodule

// File: tb/tb_reg_file_banked.sv
// tb_reg_file_banked: directed per-feature checks of reg_file_banked with default parameters.
module tb_reg_file_banked;
    logic        clk = 0, rst = 1;
    logic [4:0]  f_adrs = 0;
    logic        f_wr = 0;
    logic [7:0]  f_in_data = 0, f_out_data, pcl_in = 8'h5A, FSR;
    logic        PCL_wr, tmr0_inc = 0, tmr0_ovf;
    logic        C_en = 0, DC_en = 0, Z_en = 0, C_new = 0, DC_new = 0, Z_new = 0;
    logic        SLEEP = 0, CLRWDT = 0, wdtmr = 0, C;
    logic [23:0] port_in = 0, port_out, port_oe;
    int vec = 0, err = 0;

    always #5 clk = ~clk;

    reg_file_banked dut (
        .clk(clk), .rst(rst), .f_adrs(f_adrs), .f_wr(f_wr), .f_in_data(f_in_data),
        .f_out_data(f_out_data), .pcl_in(pcl_in), .PCL_wr(PCL_wr), .tmr0_inc(tmr0_inc),
        .tmr0_ovf(tmr0_ovf), .C_en(C_en), .DC_en(DC_en), .Z_en(Z_en), .C_new(C_new),
        .DC_new(DC_new), .Z_new(Z_new), .SLEEP(SLEEP), .CLRWDT(CLRWDT), .wdtmr(wdtmr),
        .C(C), .FSR(FSR), .port_in(port_in), .port_out(port_out), .port_oe(port_oe)
    );

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        f_adrs = a; f_in_data = d; f_wr = 1;
        @(negedge clk);
        f_wr = 0;
    endtask

    task automatic rd(input logic [4:0] a);
        f_adrs = a;
        #1;
    endtask

    task automatic test_reset;
        rst = 1; #2 rst = 0; #1;
        rd(5'h0B); vec++; if (f_out_data !== 8'h0F) begin err++; $display("FAIL reset_option got %h exp 0f", f_out_data); end
        rd(5'h03); vec++; if (f_out_data !== 8'h18) begin err++; $display("FAIL reset_status got %h exp 18", f_out_data); end
        vec++; if (port_oe !== 24'h0) begin err++; $display("FAIL reset_oe got %h exp 000000", port_oe); end
        vec++; if (port_out !== 24'h0 || FSR !== 8'h00 || tmr0_ovf !== 1'b0) begin err++; $display("FAIL reset_misc got out=%h fsr=%h ovf=%b exp 0", port_out, FSR, tmr0_ovf); end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_ports;
        wr(5'h08, 8'h0F);
        wr(5'h05, 8'hA5);
        vec++; if (port_out[7:0] !== 8'hA5) begin err++; $display("FAIL port0_out got %h exp a5", port_out[7:0]); end
        vec++; if (port_oe !== 24'h0000F0) begin err++; $display("FAIL port0_oe got %h exp 0000f0", port_oe); end
        @(negedge clk); port_in = 24'h123456;
        @(negedge clk); rd(5'h05);
        vec++; if (f_out_data !== 8'h00) begin err++; $display("FAIL sync_lat1 got %h exp 00", f_out_data); end
        @(negedge clk); rd(5'h05);
        vec++; if (f_out_data !== 8'h56) begin err++; $display("FAIL sync_port0 got %h exp 56", f_out_data); end
        rd(5'h07);
        vec++; if (f_out_data !== 8'h12) begin err++; $display("FAIL sync_port2 got %h exp 12", f_out_data); end
        rd(5'h08);
        vec++; if (f_out_data !== 8'h0F) begin err++; $display("FAIL tris0_rd got %h exp 0f", f_out_data); end
    endtask

    task automatic test_bank_indirect;
        wr(5'h03, 8'h20); wr(5'h10, 8'h20);
        wr(5'h03, 8'h00); wr(5'h10, 8'h30);
        wr(5'h04, 8'h30); @(negedge clk); rd(5'h00);
        vec++; if (f_out_data !== 8'h20) begin err++; $display("FAIL indf_bank1 got %h exp 20", f_out_data); end
        wr(5'h04, 8'h10); @(negedge clk); rd(5'h00);
        vec++; if (f_out_data !== 8'h30) begin err++; $display("FAIL indf_bank0 got %h exp 30", f_out_data); end
        wr(5'h04, 8'h00); wr(5'h00, 8'h55); @(negedge clk); rd(5'h00);
        vec++; if (f_out_data !== 8'h00) begin err++; $display("FAIL indf_null_rd got %h exp 00", f_out_data); end
        vec++; if (FSR !== 8'h00) begin err++; $display("FAIL indf_null_fsr got %h exp 00", FSR); end
        rd(5'h10);
        vec++; if (f_out_data !== 8'h30) begin err++; $display("FAIL indf_null_ram got %h exp 30", f_out_data); end
        wr(5'h04, 8'h02); @(negedge clk);
        f_adrs = 5'h00; f_wr = 1; #1;
        vec++; if (PCL_wr !== 1'b1 || f_out_data !== 8'h5A) begin err++; $display("FAIL pcl_ind got wr=%b rd=%h exp 1 5a", PCL_wr, f_out_data); end
        f_adrs = 5'h0C; #1;
        vec++; if (PCL_wr !== 1'b0) begin err++; $display("FAIL pcl_none got %b exp 0", PCL_wr); end
        f_wr = 0;
    endtask

    task automatic test_prescaler;
        wr(5'h0B, 8'h01);
        wr(5'h01, 8'hFF);
        @(negedge clk); f_adrs = 5'h01; tmr0_inc = 1;
        repeat (3) @(negedge clk);
        #1; vec++; if (f_out_data !== 8'hFF) begin err++; $display("FAIL pre_3ticks got %h exp ff", f_out_data); end
        @(negedge clk); tmr0_inc = 0; #1;
        vec++; if (f_out_data !== 8'h00 || tmr0_ovf !== 1'b1) begin err++; $display("FAIL pre_wrap got tmr=%h ovf=%b exp 00 1", f_out_data, tmr0_ovf); end
        rd(5'h0B);
        vec++; if (f_out_data !== 8'h81) begin err++; $display("FAIL t0if_set got %h exp 81", f_out_data); end
        @(negedge clk); #1;
        vec++; if (tmr0_ovf !== 1'b0) begin err++; $display("FAIL ovf_pulse got %b exp 0", tmr0_ovf); end
        wr(5'h0B, 8'h01); rd(5'h0B);
        vec++; if (f_out_data !== 8'h01) begin err++; $display("FAIL t0if_clr got %h exp 01", f_out_data); end
    endtask

    task automatic test_back_to_back;
        wr(5'h0B, 8'h08);
        @(negedge clk); f_adrs = 5'h01; f_in_data = 8'h40; f_wr = 1; tmr0_inc = 1;
        @(negedge clk); f_wr = 0; #1;
        vec++; if (f_out_data !== 8'h40) begin err++; $display("FAIL tw_load got %h exp 40", f_out_data); end
        @(negedge clk); #1;
        vec++; if (f_out_data !== 8'h40) begin err++; $display("FAIL tw_hold got %h exp 40", f_out_data); end
        @(negedge clk); #1;
        vec++; if (f_out_data !== 8'h41) begin err++; $display("FAIL tw_inc1 got %h exp 41", f_out_data); end
        @(negedge clk); tmr0_inc = 0; #1;
        vec++; if (f_out_data !== 8'h42) begin err++; $display("FAIL tw_inc2 got %h exp 42", f_out_data); end
    endtask

    task automatic test_status;
        wr(5'h03, 8'h05);
        @(negedge clk); f_adrs = 5'h03; f_in_data = 8'h02; f_wr = 1; C_en = 1; C_new = 0;
        @(negedge clk); f_wr = 0; C_en = 0; #1;
        vec++; if (C !== 1'b0 || f_out_data !== 8'h1C) begin err++; $display("FAIL flag_en got c=%b st=%h exp 0 1c", C, f_out_data); end
        @(negedge clk); SLEEP = 1; @(negedge clk); SLEEP = 0; #1;
        vec++; if (f_out_data !== 8'h14) begin err++; $display("FAIL sleep got %h exp 14", f_out_data); end
        @(negedge clk); CLRWDT = 1; @(negedge clk); CLRWDT = 0; #1;
        vec++; if (f_out_data !== 8'h1C) begin err++; $display("FAIL clrwdt got %h exp 1c", f_out_data); end
        @(negedge clk); wdtmr = 1; @(negedge clk); wdtmr = 0; #1;
        vec++; if (f_out_data !== 8'h0C) begin err++; $display("FAIL wdt got %h exp 0c", f_out_data); end
    endtask

    task automatic test_reset_mid;
        wr(5'h01, 8'h33); wr(5'h04, 8'h44); wr(5'h0B, 8'h01);
        @(negedge clk); tmr0_inc = 1;
        repeat (2) @(negedge clk);
        tmr0_inc = 0; rst = 0; #1;
        rd(5'h01); vec++; if (f_out_data !== 8'h00) begin err++; $display("FAIL rstmid_tmr got %h exp 00", f_out_data); end
        rd(5'h03); vec++; if (f_out_data !== 8'h18) begin err++; $display("FAIL rstmid_status got %h exp 18", f_out_data); end
        rd(5'h0B); vec++; if (f_out_data !== 8'h0F) begin err++; $display("FAIL rstmid_option got %h exp 0f", f_out_data); end
        vec++; if (FSR !== 8'h00 || port_out !== 24'h0 || port_oe !== 24'h0) begin err++; $display("FAIL rstmid_misc got fsr=%h out=%h oe=%h exp 0", FSR, port_out, port_oe); end
        @(negedge clk); rst = 1;
    endtask

    initial begin
        test_reset;
        test_ports;
        test_bank_indirect;
        test_prescaler;
        test_back_to_back;
        test_status;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
